mem_access_ctrl: RTL
====================

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 Parameters SHALL be, one per line:
- ADDR_WIDTH, 8, byte address width presented to Memory.
- DATA_WIDTH, 32, word width.
- READ_LATENCY, 1, cycles from the MemRead cycle until ReadData is valid (legal values 1..3).
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
- clock, in, 1, single clock, rising edge.
- reset_n, in, 1, asynchronous active-low reset.
- req_valid, in, 1, requester has a command.
- req_ready, out, 1, block accepts a command.
- req_write, in, 1, 1 = store, 0 = load.
- req_addr, in, ADDR_WIDTH, byte address.
- req_wdata, in, DATA_WIDTH, store data.
- rsp_valid, out, 1, response available.
- rsp_ready, in, 1, requester takes the response.
- rsp_rdata, out, DATA_WIDTH, load data (0 for stores and errors).
- rsp_error, out, 1, misaligned request; no memory access made.
- err_count, out, 8, saturating count of misaligned requests.
- MemRead, out, 1, Memory read strobe.
- MemWrite, out, 1, Memory write strobe.
- Address, out, ADDR_WIDTH, Memory address.
- WriteData, out, DATA_WIDTH, Memory write data.
- ReadData, in, DATA_WIDTH, Memory read data.
REQ-003 The clock SHALL be the only clock. reset_n SHALL be asynchronous and active-low.

Function
REQ-004 The FSM SHALL have four states: IDLE, ISSUE, WAIT and RESP. It SHALL enter IDLE on reset.
REQ-005 req_ready SHALL be 1 only in IDLE. Acceptance SHALL occur at a rising edge with req_valid && req_ready.
REQ-006 On acceptance the block SHALL latch req_write, req_addr and req_wdata.
REQ-007 Misaligned request (req_addr[1:0] != 0) behaviour SHALL be:
- The FSM goes IDLE -> RESP.
- rsp_error = 1 and rsp_rdata = 0.
- MemRead and MemWrite stay 0.
- err_count increments, saturating at 255.
REQ-008 An aligned request SHALL take IDLE -> ISSUE.
REQ-009 In ISSUE, for exactly one cycle:
- Address = latched address.
- For a store: MemWrite = 1 and WriteData = latched data.
- For a load: MemRead = 1.
REQ-010 ISSUE SHALL exit as follows:
- Store: go to RESP with rsp_rdata = 0 and rsp_error = 0.
- Load: go to WAIT.
REQ-011 WAIT SHALL last exactly READ_LATENCY cycles, counted by a down-counter loaded at ISSUE exit. At the final WAIT edge the block SHALL capture ReadData into rsp_rdata and go to RESP.
REQ-012 MemRead SHALL be 0 throughout WAIT. Address and WriteData SHALL hold their values until the next ISSUE.
REQ-013 In RESP, rsp_valid SHALL be 1, and rsp_rdata and rsp_error SHALL hold stable until rsp_ready = 1. On that edge the block SHALL go to IDLE with rsp_valid = 0.
REQ-014 rsp_valid timing, with the acceptance edge as N:
- Misaligned: high from edge N.
- Store: high from edge N+1.
- Load: high from edge N+1+READ_LATENCY.
REQ-015 A new request SHALL NOT be accepted in the cycle of the response handshake (at most one outstanding request). The earliest next acceptance SHALL be the edge after returning to IDLE.
REQ-016 When rsp_ready is already 1 when RESP is entered, the response SHALL complete in one cycle.
REQ-017 MemRead and MemWrite SHALL never be 1 simultaneously. Neither SHALL be 1 outside ISSUE.
REQ-018 All outputs other than req_ready SHALL be registered. req_ready SHALL be decoded from state only.

Reset
REQ-019 While reset_n = 0, outputs SHALL be forced immediately, independent of the clock:
- state = IDLE.
- MemRead = 0, MemWrite = 0.
- Address = 0, WriteData = 0.
- rsp_valid = 0, rsp_rdata = 0, rsp_error = 0.
- err_count = 0.
- req_ready = 1.
REQ-020 Reset asserted mid-operation (ISSUE, WAIT or RESP) SHALL abort the transaction: the pending response is discarded and no strobe is extended past reset assertion.
REQ-021 After reset_n deasserts, the first acceptance SHALL be possible at the first rising edge.

Verification
REQ-022 Store 0x00000002 to 0x04, rsp_ready = 1 -> one-cycle MemWrite = 1, Address = 0x04, WriteData = 0x00000002. rsp_valid rises one edge after acceptance with rsp_error = 0.
REQ-023 Stores 0x5 @ 0x08, 0x9 @ 0x0C, 0x7 @ 0x18, 0xA @ 0x1C, then loads in order 0x18, 0x04, 0x1C, 0x08, 0x0C (READ_LATENCY = 1) -> rsp_rdata = 0x7, 0x2, 0xA, 0x5, 0x9. Each load's rsp_valid comes 2 edges after acceptance.
REQ-024 Load 0x06 -> rsp_error = 1, rsp_rdata = 0, no strobe asserted, err_count increments by 1. Repeated 260 times -> err_count = 255.
REQ-025 Load 0x08 with rsp_ready = 0 for 5 cycles -> rsp_valid and rsp_rdata = 0x5 stay stable for 5 cycles, req_ready = 0 throughout, then return to IDLE on the handshake edge.
REQ-026 reset_n pulled low during WAIT of a load -> MemRead = 0 and rsp_valid = 0 immediately. After release, req_ready = 1, and no stale response ever appears.
REQ-027 READ_LATENCY = 3, load 0x1C -> rsp_valid rises at edge N+4 with rsp_rdata = 0xA.

Source files
------------

// File: rtl/mem_access_ctrl.sv
// Single-outstanding load/store bridge between a valid/ready requester and a
// simple strobe-based memory with a fixed read latency.
module mem_access_ctrl #(
  parameter int ADDR_WIDTH   = 8,
  parameter int DATA_WIDTH   = 32,
  parameter int READ_LATENCY = 1
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_error,
  output logic [7:0]            err_count,
  output logic                  MemRead,
  output logic                  MemWrite,
  output logic [ADDR_WIDTH-1:0] Address,
  output logic [DATA_WIDTH-1:0] WriteData,
  input  logic [DATA_WIDTH-1:0] ReadData
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

  localparam logic [1:0] LAT_LOAD = 2'(READ_LATENCY);

  state_e                state_q, state_d;
  logic                  wr_q, wr_d;
  logic [1:0]            lat_cnt_q, lat_cnt_d;
  logic                  mem_rd_q, mem_rd_d;
  logic                  mem_wr_q, mem_wr_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  err_q, err_d;
  logic [7:0]            err_cnt_q, err_cnt_d;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  function automatic logic is_misaligned(input logic [ADDR_WIDTH-1:0] a);
    return a[1:0] != 2'b00;
  endfunction

  always_comb begin
    state_d     = state_q;
    wr_d        = wr_q;
    lat_cnt_d   = lat_cnt_q;
    mem_rd_d    = 1'b0;
    mem_wr_d    = 1'b0;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rsp_valid_d = rsp_valid_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
    err_cnt_d   = err_cnt_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          wr_d = req_write;
          // Misaligned requests bypass memory entirely and answer at once.
          if (is_misaligned(req_addr)) begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rdata_d     = '0;
            err_d       = 1'b1;
            err_cnt_d   = sat_inc8(err_cnt_q);
          end else begin
            state_d  = ISSUE;
            addr_d   = req_addr;
            mem_rd_d = !req_write;
            mem_wr_d = req_write;
            if (req_write) wdata_d = req_wdata;
          end
        end
      end
      ISSUE: begin
        if (wr_q) begin
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          rdata_d     = '0;
          err_d       = 1'b0;
        end else begin
          state_d   = WAIT;
          lat_cnt_d = LAT_LOAD;
        end
      end
      WAIT: begin
        if (lat_cnt_q == 2'd1) begin
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          rdata_d     = ReadData;
          err_d       = 1'b0;
        end else begin
          lat_cnt_d = lat_cnt_q - 2'd1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
          rdata_d     = '0;
          err_d       = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      wr_q        <= 1'b0;
      lat_cnt_q   <= 2'd0;
      mem_rd_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
      err_cnt_q   <= 8'd0;
    end else begin
      state_q     <= state_d;
      wr_q        <= wr_d;
      lat_cnt_q   <= lat_cnt_d;
      mem_rd_q    <= mem_rd_d;
      mem_wr_q    <= mem_wr_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rdata_q;
  assign rsp_error = err_q;
  assign err_count = err_cnt_q;
  assign MemRead   = mem_rd_q;
  assign MemWrite  = mem_wr_q;
  assign Address   = addr_q;
  assign WriteData = wdata_q;

  // Strobes are exclusive and live only for the single ISSUE cycle.
  a_no_dual_strobe: assert property (@(posedge clock) disable iff (!reset_n)
    !(mem_rd_q && mem_wr_q));
  a_strobe_in_issue: assert property (@(posedge clock) disable iff (!reset_n)
    (mem_rd_q || mem_wr_q) |-> (state_q == ISSUE));

endmodule
